mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
- Parametrised multicycle MIPS core; successor to the single-cycle MIPS top.
- Replaces separate instruction and data memories with one external unified memory port that uses a req/ready handshake, so slow memories stall the core.
- Contains the PC, IR, register file, ALU and the FSM controller. Sits between the system top and a shared memory/bus.

Parameters:
- ADDR_WIDTH, 32, byte-address width of mem_addr and the PC. Valid range 8..32. PC upper bits above ADDR_WIDTH are treated as 0.
- RESET_PC, 0, PC value loaded on reset. Must be word aligned.
- TEST_REG, 2, register index whose low 16 bits drive test_value.

Ports:
- CLK, input, 1, clock; all state updates on rising edge.
- RST, input, 1, synchronous active-low reset.
- mem_req, output, 1, memory transfer request.
- mem_we, output, 1, 1 = write, 0 = read; valid while mem_req=1.
- mem_addr, output, ADDR_WIDTH, byte address; word aligned.
- mem_wdata, output, 32, store data.
- mem_rdata, input, 32, read data; sampled in the cycle mem_ready=1.
- mem_ready, input, 1, transfer completes in any cycle with mem_req=1 and mem_ready=1.
- retire, output, 1, one-cycle pulse when an instruction completes.
- illegal, output, 1, one-cycle pulse on an unsupported opcode or funct.
- test_value, output, 16, reg[TEST_REG][15:0].

Behaviour:
- Reset, sampled on the CLK edge while RST=0:
  - state <= FETCH, PC <= RESET_PC, IR <= 0, all 32 registers <= 0.
  - While RST=0, combinational gating forces mem_req=0, mem_we=0, retire=0, illegal=0.
  - Reset in any state, including mid-wait, abandons the instruction with no register or PC side effect.
- Supported instructions: add, sub, and, or, slt (R-type); lw, sw, beq, addi, j.
  - The ALU matches the existing ALUControl encoding.
  - slt is signed.
  - Arithmetic wraps mod 2^32; no overflow trap.
- Register file:
  - Combinational read, write on CLK.
  - $0 always reads 0; writes to $0 are dropped.
- Handshake:
  - mem_req=1 only in FETCH, MEMRD and MEMWR.
  - mem_addr, mem_we and mem_wdata stay stable until the ready cycle.
  - The FSM remains in the state until mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
- FSM states and transitions:
  - FETCH: addr=PC, we=0. On ready: IR <= mem_rdata, PC <= PC+4 -> DECODE.
  - DECODE: A <= rs, B <= rt, ALUOut <= PC + (signext(imm)<<2). Dispatch: lw/sw -> MEMADR, R-type -> EXEC, beq -> BRANCH, addi -> ADDIEX, j -> JUMP. Otherwise pulse illegal -> FETCH.
  - MEMADR: ALUOut <= A + signext(imm). lw -> MEMRD, sw -> MEMWR.
  - MEMRD: read at ALUOut; on ready MDR <= mem_rdata -> MEMWB.
  - MEMWB: rt <= MDR, retire -> FETCH.
  - MEMWR: write B to ALUOut, we=1; on ready retire -> FETCH.
  - EXEC: ALUOut <= A op B per funct. An unknown funct pulses illegal -> FETCH.
  - ALUWB: rd <= ALUOut, retire -> FETCH.
  - ADDIEX: ALUOut <= A + signext(imm) -> ADDIWB.
  - ADDIWB: rt <= ALUOut, retire -> FETCH.
  - BRANCH: if A==B then PC <= ALUOut; retire -> FETCH.
  - JUMP: PC <= {PC[31:28], IR[25:0], 2'b00} truncated to ADDR_WIDTH; retire -> FETCH.
- Cycle counts with zero-wait memory (mem_ready tied 1):
  - R-type 4, addi 4, sw 4, lw 5, beq 3, j 3.
  - Each memory wait cycle adds 1.
- Branch target uses PC+4 (delay-slot-free).
- Misaligned addresses: low 2 bits are driven as computed. No exception is raised; the memory ignores them.

Test Plan:
- Reset mid-MEMRD wait: assert RST=0 for 1 cycle -> next cycle mem_req=0 and the load target is unchanged. After release, mem_req=1 with mem_addr=RESET_PC.
- Zero-wait program addi $2,$0,5; addi $3,$0,7; add $2,$2,$3 -> test_value=0x000C after 12 cycles; retire pulses at cycles 4, 8 and 12.
- sw $2,8($0) then lw $4,8($0) with mem_ready low for 3 cycles per transfer -> write of 0x0000000C to addr 8. $4=0x0000000C. lw takes 5+3+3=11 cycles.
- beq $0,$0,-1 at PC 0x10 -> PC returns to 0x10 every 3 cycles. beq with unequal operands -> PC=0x14.
- j 0x40 (IR[25:0]=0x10) -> mem_addr=0x40 on the next FETCH. add to $0 -> $0 stays 0.
- Opcode 0x3F -> illegal pulses once, no register write, retire=0, next FETCH at PC+4.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core with one unified memory port using a req/ready handshake.
// The FSM holds in FETCH/MEMRD/MEMWR until the memory signals ready.
module mips_multicycle_core #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          TEST_REG   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  retire,
  output logic                  illegal,
  output logic [15:0]           test_value
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [ADDR_WIDTH-1:0] PC_RST   = RESET_PC[ADDR_WIDTH-1:0];
  localparam logic [4:0]            TEST_IDX = TEST_REG[4:0];

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]             ir_q, ir_d;
  logic [31:0]             a_q, a_d;
  logic [31:0]             b_q, b_d;
  logic [31:0]             alu_q, alu_d;
  logic [31:0]             mdr_q, mdr_d;
  logic [31:0]             rf_q [32];

  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [31:0]             rf_wdata;
  logic                    req, we, ret, ill;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [31:0]             wdata;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_se, pc_ext, rs_val, rt_val, jump_tgt;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic logic [2:0] alu_ctl(input logic [5:0] f);
    logic [2:0] c;
    case (f)
      FN_SUB:  c = ALU_SUB;
      FN_AND:  c = ALU_AND;
      FN_OR:   c = ALU_OR;
      FN_SLT:  c = ALU_SLT;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu_op(input logic [2:0] c, input logic [31:0] x,
                                         input logic [31:0] y);
    logic [31:0] r;
    case (c)
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SUB: r = x - y;
      ALU_SLT: r = {31'b0, $signed(x) < $signed(y)};
      default: r = x + y;
    endcase
    return r;
  endfunction

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign fn       = ir_q[5:0];
  assign imm_se   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_ext   = 32'(pc_q);
  assign rs_val   = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : rf_q[rt];
  assign jump_tgt = {pc_ext[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = alu_q;
    req      = 1'b0;
    we       = 1'b0;
    addr     = pc_q;
    wdata    = b_q;
    ret      = 1'b0;
    ill      = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // pc_q already holds PC+4 here, so this is the branch target
        a_d   = rs_val;
        b_d   = rt_val;
        alu_d = pc_ext + {imm_se[29:0], 2'b00};
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_d   = a_q + imm_se;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req  = 1'b1;
        addr = alu_q[ADDR_WIDTH-1:0];
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr_q;
        ret      = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = alu_q[ADDR_WIDTH-1:0];
        if (mem_ready) begin
          ret     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (funct_ok(fn)) begin
          alu_d   = alu_op(alu_ctl(fn), a_q, b_q);
          state_d = S_ALUWB;
        end else begin
          ill     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        ret      = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_d   = a_q + imm_se;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        ret      = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        if (a_q == b_q) pc_d = alu_q[ADDR_WIDTH-1:0];
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = jump_tgt[ADDR_WIDTH-1:0];
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q <= PC_RST;
      ir_q <= 32'h0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  always_ff @(posedge CLK) begin
    a_q   <= a_d;
    b_q   <= b_d;
    alu_q <= alu_d;
    mdr_q <= mdr_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Reset gates every handshake/status output combinationally
  assign mem_req    = req & RST;
  assign mem_we     = we & RST;
  assign retire     = ret & RST;
  assign illegal    = ill & RST;
  assign mem_addr   = addr;
  assign mem_wdata  = wdata;
  assign test_value = rf_q[TEST_IDX][15:0];

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: behavioural memory with programmable wait states,
// queued expected retires/illegals/writes, and an ALU vector table.
module tb_mips_multicycle_core;

  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_J = 6'h02, OP_BAD = 6'h3F;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
  localparam logic [5:0] F_OR = 6'h25, F_SLT = 6'h2A;
  localparam int NV = 10;

  typedef struct {
    logic [5:0]  fn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        mem_req, mem_we, retire, illegal;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [15:0] test_value;

  int          checks = 0;
  int          errors = 0;
  int          cyc, wait_n, wcnt;
  bit          idle_ready;
  logic [31:0] mem [0:255];
  int          exp_ret[$];
  int          exp_ill[$];
  wr_t         exp_wr[$];
  bit          prev_wait;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  vec_t        vecs [NV];

  mips_multicycle_core #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .TEST_REG(2)) dut (
    .CLK(CLK), .RST(RST),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .illegal(illegal), .test_value(test_value)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic reset_dut();
    RST = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rst_gate_req", 32'(mem_req), 32'h0);
    chk("rst_gate_retire", 32'(retire), 32'h0);
    chk("rst_gate_illegal", 32'(illegal), 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    cyc = 1;
    wcnt = 0;
    prev_wait = 1'b0;
    exp_ret.delete();
    exp_ill.delete();
    exp_wr.delete();
  endtask

  task automatic cycle();
    wr_t w;
    int  e;
    if (mem_req === 1'b1) begin
      mem_ready = (wcnt >= wait_n);
      mem_rdata = mem[mem_addr[9:2]];
    end else begin
      mem_ready = idle_ready;
      mem_rdata = 32'hDEADBEEF;
      wcnt = 0;
    end
    #1;
    if (prev_wait && mem_req) begin
      chk("hold_addr", mem_addr, prev_addr);
      chk("hold_we", 32'(mem_we), 32'(prev_we));
      if (prev_we) chk("hold_wdata", mem_wdata, prev_wdata);
    end
    if (mem_req && !mem_ready) begin
      prev_wait = 1'b1;
      prev_addr = mem_addr;
      prev_we = mem_we;
      prev_wdata = mem_wdata;
      wcnt++;
    end else begin
      prev_wait = 1'b0;
    end
    if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[9:2]] = mem_wdata;
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write at cycle %0d: addr %h data %h, none expected",
                 cyc, mem_addr, mem_wdata);
      end else begin
        w = exp_wr.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_wdata, w.data);
      end
    end
    if (mem_req && mem_ready) wcnt = 0;
    if (retire) begin
      if (exp_ret.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire at cycle %0d: got pulse expected none", cyc);
      end else begin
        e = exp_ret.pop_front();
        chk("retire_cycle", 32'(cyc), 32'(e));
      end
    end
    if (illegal) begin
      if (exp_ill.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_illegal at cycle %0d: got pulse expected none", cyc);
      end else begin
        e = exp_ill.pop_front();
        chk("illegal_cycle", 32'(cyc), 32'(e));
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    chk("retires_left", 32'(exp_ret.size()), 32'h0);
    chk("illegals_left", 32'(exp_ill.size()), 32'h0);
    chk("writes_left", 32'(exp_wr.size()), 32'h0);
  endtask

  initial begin
    vecs[0] = '{F_ADD, 16'd5,    16'd7,    32'h0000000C};
    vecs[1] = '{F_SUB, 16'd5,    16'd7,    32'hFFFFFFFE};
    vecs[2] = '{F_AND, 16'h0F0F, 16'h00FF, 32'h0000000F};
    vecs[3] = '{F_OR,  16'h0F00, 16'h00F0, 32'h00000FF0};
    vecs[4] = '{F_SLT, 16'hFFFF, 16'h0001, 32'h00000001};
    vecs[5] = '{F_SLT, 16'h0001, 16'hFFFF, 32'h00000000};
    vecs[6] = '{F_ADD, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFE};
    vecs[7] = '{F_SUB, 16'h8000, 16'h0001, 32'hFFFF7FFF};
    vecs[8] = '{F_AND, 16'h8000, 16'hFFFF, 32'hFFFF8000};
    vecs[9] = '{F_SLT, 16'h8000, 16'h7FFF, 32'h00000001};

    cyc = 0;
    wait_n = 0;
    idle_ready = 1'b0;
    clear_mem();
    reset_dut();
    chk("reset_req", 32'(mem_req), 32'h1);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_we", 32'(mem_we), 32'h0);
    chk("reset_tv", 32'(test_value), 32'h0);

    // ALU table: two addi operands, R-type op, store the result to 0x100
    for (int i = 0; i < NV; i++) begin
      clear_mem();
      wait_n = 0;
      idle_ready = 1'b1;
      mem[0] = enc_i(OP_ADDI, 5'd0, 5'd8, vecs[i].a);
      mem[1] = enc_i(OP_ADDI, 5'd0, 5'd9, vecs[i].b);
      mem[2] = enc_r(5'd8, 5'd9, 5'd10, vecs[i].fn);
      mem[3] = enc_i(OP_SW, 5'd0, 5'd10, 16'h0100);
      reset_dut();
      exp_ret.push_back(4);
      exp_ret.push_back(8);
      exp_ret.push_back(12);
      exp_ret.push_back(16);
      exp_wr.push_back('{32'h00000100, vecs[i].exp});
      run(16);
      drain();
    end

    // addi/addi/add zero-wait program
    clear_mem();
    wait_n = 0;
    idle_ready = 1'b0;
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd5);
    mem[1] = enc_i(OP_ADDI, 5'd0, 5'd3, 16'd7);
    mem[2] = enc_r(5'd2, 5'd3, 5'd2, F_ADD);
    reset_dut();
    exp_ret.push_back(4);
    exp_ret.push_back(8);
    exp_ret.push_back(12);
    run(12);
    chk("prog_tv", 32'(test_value), 32'h0000000C);
    drain();

    // jump then sw/lw with 3 wait cycles on every transfer
    clear_mem();
    wait_n = 3;
    mem[0]  = enc_j(OP_J, 26'h0000010);
    mem[16] = enc_i(OP_ADDI, 5'd0, 5'd3, 16'd12);
    mem[17] = enc_i(OP_SW, 5'd0, 5'd3, 16'h0008);
    mem[18] = enc_i(OP_LW, 5'd0, 5'd4, 16'h0008);
    mem[19] = enc_r(5'd4, 5'd0, 5'd2, F_ADD);
    reset_dut();
    exp_ret.push_back(6);
    exp_ret.push_back(13);
    exp_ret.push_back(23);
    exp_ret.push_back(34);
    exp_ret.push_back(41);
    exp_wr.push_back('{32'h00000008, 32'h0000000C});
    run(41);
    chk("lw_tv", 32'(test_value), 32'h0000000C);
    drain();

    // j 0x40: next FETCH address
    clear_mem();
    wait_n = 0;
    mem[0] = enc_j(OP_J, 26'h0000010);
    reset_dut();
    exp_ret.push_back(3);
    run(3);
    chk("j_fetch_req", 32'(mem_req), 32'h1);
    chk("j_fetch_addr", mem_addr, 32'h00000040);
    drain();

    // beq $0,$0,-1 at 0x10 loops every 3 cycles
    clear_mem();
    mem[0] = enc_j(OP_J, 26'h0000004);
    mem[4] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
    reset_dut();
    exp_ret.push_back(3);
    exp_ret.push_back(6);
    exp_ret.push_back(9);
    exp_ret.push_back(12);
    run(3);
    for (int k = 0; k < 3; k++) begin
      chk("beq_loop_pc", mem_addr, 32'h00000010);
      run(3);
    end
    chk("beq_loop_pc", mem_addr, 32'h00000010);
    drain();

    // beq with unequal operands falls through to 0x14
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd5, 16'd1);
    mem[1] = enc_j(OP_J, 26'h0000004);
    mem[4] = enc_i(OP_BEQ, 5'd5, 5'd0, 16'hFFFF);
    reset_dut();
    exp_ret.push_back(4);
    exp_ret.push_back(7);
    exp_ret.push_back(10);
    run(7);
    chk("beq_ne_fetch", mem_addr, 32'h00000010);
    run(3);
    chk("beq_ne_pc", mem_addr, 32'h00000014);
    drain();

    // writes to $0 are dropped
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd3, 16'd9);
    mem[1] = enc_r(5'd3, 5'd3, 5'd0, F_ADD);
    mem[2] = enc_r(5'd0, 5'd3, 5'd2, F_ADD);
    reset_dut();
    exp_ret.push_back(4);
    exp_ret.push_back(8);
    exp_ret.push_back(12);
    run(12);
    chk("zero_reg_tv", 32'(test_value), 32'h00000009);
    drain();

    // illegal opcode and illegal funct
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd3);
    mem[1] = enc_i(OP_BAD, 5'd0, 5'd2, 16'h1234);
    mem[2] = enc_r(5'd2, 5'd2, 5'd2, 6'h3F);
    mem[3] = enc_i(OP_ADDI, 5'd2, 5'd2, 16'd1);
    reset_dut();
    exp_ret.push_back(4);
    exp_ret.push_back(13);
    exp_ill.push_back(6);
    exp_ill.push_back(9);
    run(6);
    chk("illegal_next_pc", mem_addr, 32'h00000008);
    run(7);
    chk("illegal_tv", 32'(test_value), 32'h00000004);
    drain();

    // reset during a MEMRD wait
    clear_mem();
    wait_n = 1;
    mem[0]  = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
    mem[1]  = enc_i(OP_LW, 5'd0, 5'd2, 16'h0080);
    mem[32] = 32'h00001234;
    reset_dut();
    exp_ret.push_back(5);
    run(9);
    chk("midwait_req", 32'(mem_req), 32'h1);
    chk("midwait_addr", mem_addr, 32'h00000080);
    chk("midwait_tv", 32'(test_value), 32'h00000007);
    drain();
    RST = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'h0);
    chk("midrst_we", 32'(mem_we), 32'h0);
    chk("midrst_retire", 32'(retire), 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("midrst_req_after", 32'(mem_req), 32'h0);
    chk("midrst_tv", 32'(test_value), 32'h0);
    RST = 1'b1;
    #1;
    chk("release_req", 32'(mem_req), 32'h1);
    chk("release_addr", mem_addr, 32'h0);
    cyc = 1;
    wcnt = 0;
    prev_wait = 1'b0;
    run(4);
    chk("release_tv", 32'(test_value), 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
